button_debouncer_multi: RTL

Parametrised multi-channel successor to the single-button pulse debouncer. It synchronises NUM_BTNS asynchronous button inputs and debounces each one independently with a stability filter. Per channel it outputs a clean level, one-cycle press and release pulses, a one-shot long-press pulse and an auto-repeat pulse train while the button is held. It sits between the board push-buttons and the user-interface control logic, such as step/reset controls of the fibonacci and counter designs.

---
 rtl/button_debouncer_multi.sv | 133 +++++++++++++
 1 files changed

// File: rtl/button_debouncer_multi.sv
// Multi-channel button conditioner: per-channel synchroniser, debounce filter,
// press/release pulses, one-shot long press and auto-repeat while held.
module button_debouncer_multi #(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_BTNS-1:0] btn_i,
  output logic [NUM_BTNS-1:0] level_o,
  output logic [NUM_BTNS-1:0] press_o,
  output logic [NUM_BTNS-1:0] release_o,
  output logic [NUM_BTNS-1:0] long_o,
  output logic [NUM_BTNS-1:0] repeat_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  // A zero-valued HOLD/REPEAT disables the feature; keep a 1-bit counter so widths stay legal.
  localparam int unsigned HW = (HOLD_CYCLES == 0)   ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RW = (REPEAT_CYCLES == 0) ? 1 : $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q    [NUM_BTNS];
  state_t                 state_q   [NUM_BTNS];
  logic [DW-1:0]          deb_q     [NUM_BTNS];
  logic [HW-1:0]          hold_q    [NUM_BTNS];
  logic [RW-1:0]          rep_q     [NUM_BTNS];
  logic [NUM_BTNS-1:0]    rep_phase_q;
  logic [NUM_BTNS-1:0]    s;

  always_comb begin
    s = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= IDLE;
        deb_q[i]   <= '0;
        hold_q[i]  <= '0;
        rep_q[i]   <= '0;
      end
      rep_phase_q <= '0;
      level_o     <= '0;
      press_o     <= '0;
      release_o   <= '0;
      long_o      <= '0;
      repeat_o    <= '0;
    end else begin
      press_o   <= '0;
      release_o <= '0;
      long_o    <= '0;
      repeat_o  <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_i[i]};
        case (state_q[i])
          IDLE: begin
            if (s[i]) begin
              state_q[i] <= PRESS_CHK;
              deb_q[i]   <= '0;
            end
          end
          PRESS_CHK: begin
            if (!s[i]) begin
              state_q[i] <= IDLE;
            end else if (deb_q[i] == DEB_LAST) begin
              state_q[i]     <= HELD;
              press_o[i]     <= 1'b1;
              level_o[i]     <= 1'b1;
              hold_q[i]      <= '0;
              rep_q[i]       <= '0;
              rep_phase_q[i] <= 1'b0;
            end else begin
              deb_q[i] <= deb_q[i] + DW'(1);
            end
          end
          HELD: begin
            if (!s[i]) begin
              state_q[i] <= RELEASE_CHK;
              deb_q[i]   <= '0;
            end else if (HOLD_CYCLES != 0 && !rep_phase_q[i]) begin
              if (hold_q[i] == HOLD_LAST) begin
                long_o[i]      <= 1'b1;
                rep_phase_q[i] <= 1'b1;
                rep_q[i]       <= '0;
              end else begin
                hold_q[i] <= hold_q[i] + HW'(1);
              end
            end else if (rep_phase_q[i] && REPEAT_CYCLES != 0) begin
              if (rep_q[i] == REP_LAST) begin
                repeat_o[i] <= 1'b1;
                rep_q[i]    <= '0;
              end else begin
                rep_q[i] <= rep_q[i] + RW'(1);
              end
            end
          end
          RELEASE_CHK: begin
            // Hold/repeat progress is kept across a rejected release glitch.
            if (s[i]) begin
              state_q[i] <= HELD;
            end else if (deb_q[i] == DEB_LAST) begin
              state_q[i]   <= IDLE;
              release_o[i] <= 1'b1;
              level_o[i]   <= 1'b0;
            end else begin
              deb_q[i] <= deb_q[i] + DW'(1);
            end
          end
          default: state_q[i] <= IDLE;
        endcase
      end
    end
  end

endmodule
